sram_block_mover: RTL and testbench
===================================

Name: sram_block_mover

Overview:
- Bus initiator that drives the SRAM controller's stb/we/addra/dina/douta/ACK port, either the video port or the CPU port.
- Executes one queued command at a time: a block copy (SRAM to SRAM, word by word) or a block fill (constant word to a range).
- Used for screen clear, scroll and framebuffer moves without CPU involvement.
- Sits between the command register block and the controller's v_* port.

Parameters:
- MIN_HOLD_RD, 1: minimum cycles m_stb stays high on a read before ACK may complete it.
- MIN_HOLD_WR, 4: minimum cycles m_stb stays high on a write before ACK may complete it. This covers the controller's 4-phase read-modify-write.
- TIMEOUT, 255: cycles a request may wait for ACK before the command aborts.

Ports:
- clk_50mhz  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high in IDLE only; a command is accepted on an edge where cmd_valid && cmd_ready.
- cmd_op  in  1  0 = copy, 1 = fill.
- cmd_src  in  20  copy source start word address; ignored for fill.
- cmd_dst  in  20  destination start word address.
- cmd_len  in  20  number of words to transfer.
- cmd_fill  in  48  fill word.
- busy  out  1  high from acceptance until the command finishes.
- done  out  1  one-cycle pulse on successful completion.
- err  out  1  one-cycle pulse on timeout abort.
- words_done  out  20  words written so far in the current or last command.
- m_stb  out  1  request strobe to controller.
- m_we  out  1  write enable; qualified by m_stb.
- m_addra  out  20  request address.
- m_dina  out  48  write data.
- m_douta  in  48  read data from controller.
- m_ack  in  1  controller ready/ACK.

Behaviour:
- Reset (asynchronous, rst_n = 0). State goes to IDLE. Outputs: m_stb = 0, m_we = 0, m_addra = 0, m_dina = 0, busy = 0, done = 0, err = 0, words_done = 0, cmd_ready = 1 after release. Reset mid-transfer drops m_stb immediately with no completion.
- States: IDLE, RD_REQ, RD_GAP, WR_REQ, WR_GAP, FIN, ABORT.
- IDLE, on accept:
  - Latch src, dst and len into working registers; clear words_done; busy = 1.
  - If len = 0, go to FIN.
  - Else copy goes to RD_REQ; fill goes to WR_REQ with the data register = cmd_fill.
- Request rules (RD_REQ, WR_REQ):
  - m_stb = 1; m_addra, m_we and m_dina are held constant for the whole request.
  - A hold counter clears on entry and increments each cycle.
  - Completion is the first rising edge with m_ack = 1 and hold counter >= MIN_HOLD−1 (counter counts from 0 on the entry cycle). A read therefore takes at least 1 cycle, a write at least 4. ACK arriving earlier than that is ignored.
- RD_REQ: m_we = 0, m_addra = src. On completion, capture m_douta into the data register, src += 1, go to RD_GAP.
- WR_REQ: m_we = 1, m_addra = dst, m_dina = data register. On completion, dst += 1, words_done += 1, len −= 1, go to WR_GAP.
- Gap states: m_stb = 0 and m_we = 0 for exactly one cycle, so the controller's write phase counter returns to 0.
  - RD_GAP goes to WR_REQ.
  - WR_GAP goes to FIN if len = 0; otherwise copy goes to RD_REQ and fill goes to WR_REQ.
- FIN: done = 1 for one cycle, busy = 0, return to IDLE.
- Timeout: a request waiting TIMEOUT cycles without completion goes to ABORT. ABORT drops m_stb, pulses err for one cycle, busy = 0, returns to IDLE. words_done keeps the count reached.
- Address arithmetic: 20-bit modulo; 20'hFFFFF + 1 wraps to 20'h00000 with no error.
- Overlapping copy: strictly ascending addresses, one word at a time. Overlap with dst > src propagates data; this is required behaviour, not an error.
- cmd_valid while busy: ignored, since cmd_ready = 0. cmd_valid on the same edge busy falls is not accepted until the next IDLE cycle.
- Outside requests: m_dina is don't-care when m_we = 0, but is still driven (never high-Z).

Test Plan:
1. Fill: dst = 20'h80000, len = 3, fill = 48'h08080000_0000, ACK always high -> exactly 3 write strobes, each 4 cycles, at 80000/80001/80002; one low cycle between strobes; done pulses once; words_done = 3.
2. Copy: src = 20'h00010, len = 2, dst = 20'h80100; model returns A1, A2 -> read 10, write 80100 = A1, read 11, write 80101 = A2; done once.
3. len = 0 -> no m_stb; done pulses 2 cycles after acceptance; words_done = 0.
4. ACK held low on the second write of a fill, len = 4 -> after 255 cycles m_stb drops; err pulses; words_done = 1; busy = 0; the next command is accepted.
5. Fill with dst = 20'hFFFFF, len = 2 -> writes at FFFFF then 00000; no error.
6. Assert rst_n = 0 mid-write -> m_stb = 0 asynchronously; after release, cmd_ready = 1, busy = 0, words_done = 0; a cmd_valid during busy in a separate run is not accepted.

Source files
------------

// File: rtl/sram_block_mover_if.sv
// sram_block_mover_if: request/ack bus between the block mover and the SRAM controller port
//   stb   - request strobe          we    - write enable, qualified by stb
//   addra - request word address    dina  - write data
//   douta - read data               ack   - controller ready/acknowledge
interface sram_block_mover_if;
    logic        stb;
    logic        we;
    logic [19:0] addra;
    logic [47:0] dina;
    logic [47:0] douta;
    logic        ack;
    modport master (output stb, we, addra, dina, input douta, ack);
    modport slave  (input stb, we, addra, dina, output douta, ack);
endinterface

// File: rtl/sram_block_mover.sv
// sram_block_mover: executes one block copy or block fill at a time over an SRAM controller port
//   clk_50mhz, rst_n        - clock, asynchronous active-low reset
//   cmd_valid/cmd_ready     - command handshake; cmd_op 0 = copy, 1 = fill
//   cmd_src/dst/len/fill    - copy source, destination, word count, fill word
//   busy, done, err         - command in flight, success pulse, timeout pulse
//   words_done              - words written in the current or last command
//   m                       - request bus to the controller (master side)
module sram_block_mover #(
    parameter int MIN_HOLD_RD = 1,
    parameter int MIN_HOLD_WR = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic               clk_50mhz,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_op,
    input  logic [19:0]        cmd_src,
    input  logic [19:0]        cmd_dst,
    input  logic [19:0]        cmd_len,
    input  logic [47:0]        cmd_fill,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [19:0]        words_done,
    sram_block_mover_if.master m
);
    typedef enum logic [2:0] {IDLE, RD_REQ, RD_GAP, WR_REQ, WR_GAP, FIN, ABORT} state_t;
    state_t      state;
    logic [19:0] src, dst, len, addra;
    logic [47:0] data;
    logic [15:0] hold, hold_n;
    logic        op, stb, we;
    logic        rd_ok, wr_ok, expired;

    // hold counts from 0 on the first strobe cycle, so hold_n is the number of cycles strobed so far
    assign hold_n    = hold + 16'd1;
    assign rd_ok     = m.ack && hold_n >= 16'(MIN_HOLD_RD);
    assign wr_ok     = m.ack && hold_n >= 16'(MIN_HOLD_WR);
    assign expired   = hold_n == 16'(TIMEOUT);
    assign cmd_ready = state == IDLE;
    assign m.stb     = stb;
    assign m.we      = we;
    assign m.addra   = addra;
    assign m.dina    = data;

    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            src        <= '0;
            dst        <= '0;
            len        <= '0;
            data       <= '0;
            hold       <= '0;
            op         <= 1'b0;
            stb        <= 1'b0;
            we         <= 1'b0;
            addra      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            words_done <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: if (cmd_valid) begin
                    src        <= cmd_src;
                    dst        <= cmd_dst;
                    len        <= cmd_len;
                    op         <= cmd_op;
                    words_done <= '0;
                    busy       <= 1'b1;
                    hold       <= '0;
                    if (cmd_op) data <= cmd_fill;
                    if (cmd_len == '0) state <= FIN;
                    else if (cmd_op) begin
                        state <= WR_REQ;
                        stb   <= 1'b1;
                        we    <= 1'b1;
                        addra <= cmd_dst;
                    end else begin
                        state <= RD_REQ;
                        stb   <= 1'b1;
                        addra <= cmd_src;
                    end
                end
                RD_REQ: if (rd_ok) begin
                    data  <= m.douta;
                    src   <= src + 20'd1;
                    stb   <= 1'b0;
                    state <= RD_GAP;
                end else if (expired) begin
                    stb   <= 1'b0;
                    state <= ABORT;
                end else hold <= hold_n;
                RD_GAP: begin
                    state <= WR_REQ;
                    stb   <= 1'b1;
                    we    <= 1'b1;
                    addra <= dst;
                    hold  <= '0;
                end
                WR_REQ: if (wr_ok) begin
                    dst        <= dst + 20'd1;
                    words_done <= words_done + 20'd1;
                    len        <= len - 20'd1;
                    stb        <= 1'b0;
                    we         <= 1'b0;
                    state      <= WR_GAP;
                end else if (expired) begin
                    stb   <= 1'b0;
                    we    <= 1'b0;
                    state <= ABORT;
                end else hold <= hold_n;
                // one idle cycle between requests lets the controller's write phase counter reset
                WR_GAP: begin
                    hold <= '0;
                    if (len == '0) state <= FIN;
                    else if (op) begin
                        state <= WR_REQ;
                        stb   <= 1'b1;
                        we    <= 1'b1;
                        addra <= dst;
                    end else begin
                        state <= RD_REQ;
                        stb   <= 1'b1;
                        addra <= src;
                    end
                end
                FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                ABORT: begin
                    err   <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_block_mover.sv
// tb_sram_block_mover: directed self-checking bench for sram_block_mover
module tb_sram_block_mover;
    logic        clk_50mhz = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_op = 1'b0;
    logic [19:0] cmd_src = '0, cmd_dst = '0, cmd_len = '0;
    logic [47:0] cmd_fill = '0;
    logic        busy, done, err;
    logic [19:0] words_done;
    logic        ack_en = 1'b1;
    logic        stall_en = 1'b0;
    logic [19:0] stall_addr = '0;
    int          checks = 0;
    int          errors = 0;

    sram_block_mover_if m();

    sram_block_mover dut (
        .clk_50mhz (clk_50mhz),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_src   (cmd_src),
        .cmd_dst   (cmd_dst),
        .cmd_len   (cmd_len),
        .cmd_fill  (cmd_fill),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .words_done(words_done),
        .m         (m)
    );

    always #10 clk_50mhz = ~clk_50mhz;

    // controller model: read data encodes the address, ack can be withheld for one address
    assign m.douta = {28'hA5A5000, m.addra};
    assign m.ack   = ack_en && !(stall_en && m.addra == stall_addr);

    typedef struct packed {
        logic [19:0] addr;
        logic        we;
        logic [47:0] dina;
        int          cyc;
        int          gap;
    } rec_t;

    rec_t q[$];
    rec_t cur;
    int   low_run = 0, done_cnt = 0, err_cnt = 0, unstable = 0;
    logic prev_stb = 1'b0;

    // bus monitor: one record per strobe, with its length and the idle cycles before it
    always @(negedge clk_50mhz) begin
        if (m.stb) begin
            if (!prev_stb) begin
                cur.addr = m.addra;
                cur.we   = m.we;
                cur.dina = m.dina;
                cur.cyc  = 1;
                cur.gap  = low_run;
            end else begin
                cur.cyc = cur.cyc + 1;
                if (m.addra !== cur.addr || m.we !== cur.we || m.dina !== cur.dina) unstable = unstable + 1;
            end
            low_run = 0;
        end else begin
            if (prev_stb) q.push_back(cur);
            low_run = low_run + 1;
        end
        prev_stb = m.stb;
        done_cnt = done_cnt + int'(done);
        err_cnt  = err_cnt + int'(err);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send(input logic op, input logic [19:0] s, input logic [19:0] d,
                        input logic [19:0] l, input logic [47:0] f);
        @(posedge clk_50mhz);
        #1;
        q.delete();
        done_cnt = 0;
        err_cnt  = 0;
        unstable = 0;
        @(negedge clk_50mhz);
        check("ready before send", cmd_ready, 1);
        cmd_op    = op;
        cmd_src   = s;
        cmd_dst   = d;
        cmd_len   = l;
        cmd_fill  = f;
        cmd_valid = 1'b1;
        @(posedge clk_50mhz);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        int n = 0;
        while (!done && !err && n < 2000) begin
            @(negedge clk_50mhz);
            n++;
        end
        check({tag, " finished"}, n < 2000, 1);
        repeat (2) @(negedge clk_50mhz);
    endtask

    task automatic chk_rec(input string tag, input int i, input logic [19:0] a, input logic w,
                           input logic [47:0] d, input int c);
        if (i < q.size()) begin
            check({tag, " addr"}, q[i].addr, a);
            check({tag, " we"}, q[i].we, w);
            if (w) check({tag, " dina"}, q[i].dina, d);
            check({tag, " cycles"}, q[i].cyc, c);
            if (i > 0) check({tag, " gap"}, q[i].gap, 1);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk_50mhz);
        check("reset stb", m.stb, 0);
        check("reset we", m.we, 0);
        check("reset addra", m.addra, 0);
        check("reset dina", m.dina, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset err", err, 0);
        check("reset words_done", words_done, 0);
        rst_n = 1'b1;
        @(negedge clk_50mhz);
        check("ready after reset", cmd_ready, 1);

        // fill of three words
        send(1'b1, 20'h0, 20'h80000, 20'd3, 48'h080800000000);
        wait_end("fill");
        check("fill strobes", q.size(), 3);
        for (int i = 0; i < 3; i++) chk_rec("fill wr", i, 20'h80000 + 20'(i), 1'b1, 48'h080800000000, 4);
        check("fill done pulses", done_cnt, 1);
        check("fill err pulses", err_cnt, 0);
        check("fill words_done", words_done, 3);
        check("fill busy", busy, 0);
        check("fill stable", unstable, 0);

        // copy of two words
        send(1'b0, 20'h00010, 20'h80100, 20'd2, 48'h0);
        wait_end("copy");
        check("copy strobes", q.size(), 4);
        chk_rec("copy rd0", 0, 20'h00010, 1'b0, 48'h0, 1);
        chk_rec("copy wr0", 1, 20'h80100, 1'b1, 48'hA5A500000010, 4);
        chk_rec("copy rd1", 2, 20'h00011, 1'b0, 48'h0, 1);
        chk_rec("copy wr1", 3, 20'h80101, 1'b1, 48'hA5A500000011, 4);
        check("copy done pulses", done_cnt, 1);
        check("copy words_done", words_done, 2);
        check("copy stable", unstable, 0);

        // zero-length command
        send(1'b1, 20'h0, 20'h12345, 20'd0, 48'h1);
        @(negedge clk_50mhz);
        check("len0 busy", busy, 1);
        check("len0 done early", done, 0);
        @(negedge clk_50mhz);
        check("len0 done", done, 1);
        repeat (2) @(negedge clk_50mhz);
        check("len0 strobes", q.size(), 0);
        check("len0 done pulses", done_cnt, 1);
        check("len0 words_done", words_done, 0);

        // timeout on the second write
        stall_en   = 1'b1;
        stall_addr = 20'h00201;
        send(1'b1, 20'h0, 20'h00200, 20'd4, 48'h123456789ABC);
        wait_end("timeout");
        check("timeout strobes", q.size(), 2);
        chk_rec("timeout wr0", 0, 20'h00200, 1'b1, 48'h123456789ABC, 4);
        chk_rec("timeout wr1", 1, 20'h00201, 1'b1, 48'h123456789ABC, 255);
        check("timeout err pulses", err_cnt, 1);
        check("timeout done pulses", done_cnt, 0);
        check("timeout words_done", words_done, 1);
        check("timeout busy", busy, 0);
        check("timeout stb", m.stb, 0);
        stall_en = 1'b0;
        send(1'b1, 20'h0, 20'h00000, 20'd0, 48'h0);
        wait_end("after abort");
        check("after abort done", done_cnt, 1);

        // address wrap
        send(1'b1, 20'h0, 20'hFFFFF, 20'd2, 48'hCAFE0000BEEF);
        wait_end("wrap");
        check("wrap strobes", q.size(), 2);
        chk_rec("wrap wr0", 0, 20'hFFFFF, 1'b1, 48'hCAFE0000BEEF, 4);
        chk_rec("wrap wr1", 1, 20'h00000, 1'b1, 48'hCAFE0000BEEF, 4);
        check("wrap err pulses", err_cnt, 0);
        check("wrap done pulses", done_cnt, 1);

        // command offered while busy is ignored
        send(1'b1, 20'h0, 20'h00400, 20'd2, 48'h111111111111);
        @(negedge clk_50mhz);
        cmd_dst   = 20'h00500;
        cmd_len   = 20'd1;
        cmd_valid = 1'b1;
        check("busy ready", cmd_ready, 0);
        check("busy busy", busy, 1);
        repeat (4) @(negedge clk_50mhz);
        cmd_valid = 1'b0;
        wait_end("busy");
        check("busy strobes", q.size(), 2);
        chk_rec("busy wr0", 0, 20'h00400, 1'b1, 48'h111111111111, 4);
        chk_rec("busy wr1", 1, 20'h00401, 1'b1, 48'h111111111111, 4);
        repeat (3) @(negedge clk_50mhz);
        check("busy no extra", q.size(), 2);

        // asynchronous reset during the second write
        send(1'b1, 20'h0, 20'h00300, 20'd5, 48'h222222222222);
        repeat (7) @(negedge clk_50mhz);
        check("pre-reset stb", m.stb, 1);
        check("pre-reset words_done", words_done, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async stb", m.stb, 0);
        check("async we", m.we, 0);
        check("async busy", busy, 0);
        repeat (2) @(negedge clk_50mhz);
        rst_n = 1'b1;
        @(negedge clk_50mhz);
        check("post-reset ready", cmd_ready, 1);
        check("post-reset busy", busy, 0);
        check("post-reset words_done", words_done, 0);
        check("post-reset done", done, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
